// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter.
//   arb_state_t : sequencer states (idle / issue strobe / wait for read data)
//   port_id_t   : owner id of the requester that won arbitration
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_LCD = 1'b1
    } port_id_t;

endpackage

// File: rtl/sram_port_arbiter_prio.sv
// Winner select for the SRAM port arbiter, plus the starvation counter.
//   clk, sys_rst : clock, synchronous active-low reset
//   idle         : arbiter is in its sampling state this cycle
//   cpu_req      : CPU request level
//   lcd_req      : LCD request level
//   winner       : combinational owner id for the current request set
module sram_port_arbiter_prio
    import sram_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic     clk,
    input  logic     sys_rst,
    input  logic     idle,
    input  logic     cpu_req,
    input  logic     lcd_req,
    output port_id_t winner
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt;
    logic          starved;

    assign starved = (starve_cnt == SW'(STARVE_MAX));

    always_comb begin
        winner = PORT_CPU;
        if (lcd_req && (!cpu_req || starved))
            winner = PORT_LCD;
    end

    // With lcd_req high in idle a grant always happens, so the only
    // increment case is a CPU win over a waiting LCD.
    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            starve_cnt <= '0;
        end else if (idle) begin
            if (!lcd_req || winner == PORT_LCD)
                starve_cnt <= '0;
            else if (!starved)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between the CPU and LCD ports.
// One request is latched at a time; the winner gets a one-cycle gnt,
// the SRAM strobe is issued for one cycle, and a one-cycle ack follows
// (with registered read data for reads).
//   clk, sys_rst              : clock, synchronous active-low reset
//   cpu_req/we/addr/wdata     : CPU request inputs (sampled in IDLE only)
//   cpu_gnt/ack/rdata         : CPU grant pulse, done pulse, read data
//   lcd_*                     : same set for the LCD port
//   sram_addr/wr_data         : registered SRAM address / write data
//   sram_rd_en/wr_en          : SRAM strobes
//   sram_rd_data              : SRAM read data, valid RD_LAT cycles after rd_en
//
//   state     | meaning
//   ARB_IDLE  | sample requests, pick winner, latch its access
//   ARB_ISSUE | gnt and SRAM strobe high for one cycle
//   ARB_WAIT  | RD_LAT cycles waiting for read data, then ack
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       sys_rst,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_gnt,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    input  logic       lcd_req,
    input  logic       lcd_we,
    input  logic [7:0] lcd_addr,
    input  logic [7:0] lcd_wdata,
    output logic       lcd_gnt,
    output logic       lcd_ack,
    output logic [7:0] lcd_rdata,
    output logic [7:0] sram_addr,
    output logic [7:0] sram_wr_data,
    output logic       sram_rd_en,
    output logic       sram_wr_en,
    input  logic [7:0] sram_rd_data
);

    localparam int CW = $clog2(RD_LAT + 1);

    arb_state_t    state;
    port_id_t      owner;
    port_id_t      winner;
    logic          lat_we;
    logic [CW-1:0] wait_cnt;

    logic          sel_we;
    logic [7:0]    sel_addr;
    logic [7:0]    sel_wdata;

    sram_port_arbiter_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk     (clk),
        .sys_rst (sys_rst),
        .idle    (state == ARB_IDLE),
        .cpu_req (cpu_req),
        .lcd_req (lcd_req),
        .winner  (winner)
    );

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (winner == PORT_LCD) begin
            sel_we    = lcd_we;
            sel_addr  = lcd_addr;
            sel_wdata = lcd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            state        <= ARB_IDLE;
            owner        <= PORT_CPU;
            lat_we       <= 1'b0;
            wait_cnt     <= '0;
            cpu_gnt      <= 1'b0;
            cpu_ack      <= 1'b0;
            cpu_rdata    <= '0;
            lcd_gnt      <= 1'b0;
            lcd_ack      <= 1'b0;
            lcd_rdata    <= '0;
            sram_addr    <= '0;
            sram_wr_data <= '0;
            sram_rd_en   <= 1'b0;
            sram_wr_en   <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    cpu_ack <= 1'b0;
                    lcd_ack <= 1'b0;
                    if (cpu_req || lcd_req) begin
                        owner        <= winner;
                        lat_we       <= sel_we;
                        sram_addr    <= sel_addr;
                        sram_wr_data <= sel_wdata;
                        sram_rd_en   <= ~sel_we;
                        sram_wr_en   <= sel_we;
                        cpu_gnt      <= (winner == PORT_CPU);
                        lcd_gnt      <= (winner == PORT_LCD);
                        state        <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    cpu_gnt    <= 1'b0;
                    lcd_gnt    <= 1'b0;
                    sram_rd_en <= 1'b0;
                    sram_wr_en <= 1'b0;
                    if (lat_we) begin
                        cpu_ack <= (owner == PORT_CPU);
                        lcd_ack <= (owner == PORT_LCD);
                        state   <= ARB_IDLE;
                    end else begin
                        wait_cnt <= CW'(RD_LAT - 1);
                        state    <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (wait_cnt == '0) begin
                        if (owner == PORT_CPU) begin
                            cpu_rdata <= sram_rd_data;
                            cpu_ack   <= 1'b1;
                        end else begin
                            lcd_rdata <= sram_rd_data;
                            lcd_ack   <= 1'b1;
                        end
                        state <= ARB_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic       cpu_req, cpu_we, lcd_req, lcd_we;
    logic [7:0] cpu_addr, cpu_wdata, lcd_addr, lcd_wdata;
    logic       cpu_gnt, cpu_ack, lcd_gnt, lcd_ack;
    logic [7:0] cpu_rdata, lcd_rdata;
    logic [7:0] sram_addr, sram_wr_data, sram_rd_data;
    logic       sram_rd_en, sram_wr_en;

    // second build with RD_LAT=3, CPU port only driven
    logic       b_cpu_req, b_cpu_we;
    logic [7:0] b_cpu_addr, b_cpu_wdata;
    logic       b_cpu_gnt, b_cpu_ack, b_lcd_gnt, b_lcd_ack;
    logic [7:0] b_cpu_rdata, b_lcd_rdata;
    logic [7:0] b_sram_addr, b_sram_wr_data, b_sram_rd_data;
    logic       b_sram_rd_en, b_sram_wr_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) dut (
        .clk(clk), .sys_rst(sys_rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .lcd_req(lcd_req), .lcd_we(lcd_we), .lcd_addr(lcd_addr), .lcd_wdata(lcd_wdata),
        .lcd_gnt(lcd_gnt), .lcd_ack(lcd_ack), .lcd_rdata(lcd_rdata),
        .sram_addr(sram_addr), .sram_wr_data(sram_wr_data),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_rd_data(sram_rd_data)
    );

    sram_port_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .sys_rst(sys_rst),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_gnt(b_cpu_gnt), .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .lcd_req(1'b0), .lcd_we(1'b0), .lcd_addr(8'h00), .lcd_wdata(8'h00),
        .lcd_gnt(b_lcd_gnt), .lcd_ack(b_lcd_ack), .lcd_rdata(b_lcd_rdata),
        .sram_addr(b_sram_addr), .sram_wr_data(b_sram_wr_data),
        .sram_rd_en(b_sram_rd_en), .sram_wr_en(b_sram_wr_en), .sram_rd_data(b_sram_rd_data)
    );

    // SRAM models: mem[i] = 3*i+1 at start; RD_LAT=1 and RD_LAT=3 read pipes
    logic [7:0] mem  [256];
    logic [7:0] mem3 [256];
    logic [7:0] d1, d2, d3;
    bit         mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]  <= 8'(i * 3 + 1);
                mem3[i] <= 8'(i * 3 + 1);
            end
            sram_rd_data <= 8'h00;
            d1 <= 8'h00; d2 <= 8'h00; d3 <= 8'h00;
            mem_init <= 1'b1;
        end else begin
            if (sram_wr_en) mem[sram_addr] <= sram_wr_data;
            if (sram_rd_en) sram_rd_data <= mem[sram_addr];
            if (b_sram_wr_en) mem3[b_sram_addr] <= b_sram_wr_data;
            if (b_sram_rd_en) d1 <= mem3[b_sram_addr];
            d2 <= d1;
            d3 <= d2;
        end
    end
    assign b_sram_rd_data = d3;

    // per-cycle invariants
    always @(negedge clk) begin
        checks++;
        assert (!(sram_rd_en && sram_wr_en) && !(cpu_gnt && lcd_gnt) && !(cpu_ack && lcd_ack)
                && !(b_sram_rd_en && b_sram_wr_en)) else begin
            errors++;
            $error("FAIL invariant observed rd_en=%0b wr_en=%0b gnt=%0b%0b ack=%0b%0b expected no overlap",
                   sram_rd_en, sram_wr_en, cpu_gnt, lcd_gnt, cpu_ack, lcd_ack);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cpu_gnt"},   32'(cpu_gnt), 32'd0);
        check({tag, "_cpu_ack"},   32'(cpu_ack), 32'd0);
        check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
        check({tag, "_lcd_gnt"},   32'(lcd_gnt), 32'd0);
        check({tag, "_lcd_ack"},   32'(lcd_ack), 32'd0);
        check({tag, "_lcd_rdata"}, 32'(lcd_rdata), 32'd0);
        check({tag, "_sram_addr"}, 32'(sram_addr), 32'd0);
        check({tag, "_sram_wdat"}, 32'(sram_wr_data), 32'd0);
        check({tag, "_rd_en"},     32'(sram_rd_en), 32'd0);
        check({tag, "_wr_en"},     32'(sram_wr_en), 32'd0);
    endtask

    initial begin
        int gcount;
        int guard;
        logic [5:0] gseq;   // bit k = 1 when grant k went to LCD

        sys_rst = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        lcd_req = 0; lcd_we = 0; lcd_addr = 0; lcd_wdata = 0;
        b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
        repeat (3) step();
        check_outputs_zero("reset");
        check("reset_starve", 32'(dut.u_prio.starve_cnt), 32'd0);
        sys_rst = 1'b1;
        step();

        // 1: CPU write 0x5A @0x75, then back-to-back read of 0x75
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h75; cpu_wdata = 8'h5A;
        step();                                        // T1
        check("t1_wr_gnt",   32'(cpu_gnt), 32'd1);
        check("t1_wr_en",    32'(sram_wr_en), 32'd1);
        check("t1_rd_en",    32'(sram_rd_en), 32'd0);
        check("t1_addr",     32'(sram_addr), 32'h75);
        check("t1_wdata",    32'(sram_wr_data), 32'h5A);
        check("t1_ack_early",32'(cpu_ack), 32'd0);
        cpu_we = 0;
        step();                                        // T2: write ack
        check("t1_wr_ack",   32'(cpu_ack), 32'd1);
        check("t1_wr_en_off",32'(sram_wr_en), 32'd0);
        check("t1_gnt_off",  32'(cpu_gnt), 32'd0);
        step();                                        // read T1
        check("t1_rd_gnt",   32'(cpu_gnt), 32'd1);
        check("t1_rd_strobe",32'(sram_rd_en), 32'd1);
        check("t1_rd_wr_en", 32'(sram_wr_en), 32'd0);
        cpu_req = 0;
        step();                                        // WAIT
        check("t1_rd_wait_ack", 32'(cpu_ack), 32'd0);
        check("t1_rd_en_off",   32'(sram_rd_en), 32'd0);
        step();                                        // read ack
        check("t1_rd_ack",   32'(cpu_ack), 32'd1);
        check("t1_rdata",    32'(cpu_rdata), 32'h5A);
        check("t1_lcd_gnt",  32'(lcd_gnt), 32'd0);
        check("t1_lcd_ack",  32'(lcd_ack), 32'd0);
        check("t1_lcd_rdata",32'(lcd_rdata), 32'd0);
        step();
        check("t1_ack_pulse",32'(cpu_ack), 32'd0);

        // 2: simultaneous reads, CPU 0x10 (0x31), LCD 0x20 (0x61)
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        lcd_req = 1; lcd_we = 0; lcd_addr = 8'h20;
        step();
        check("t2_cpu_gnt",  32'(cpu_gnt), 32'd1);
        check("t2_lcd_gnt0", 32'(lcd_gnt), 32'd0);
        cpu_req = 0;
        step();
        step();
        check("t2_cpu_ack",  32'(cpu_ack), 32'd1);
        check("t2_cpu_rdata",32'(cpu_rdata), 32'h31);
        check("t2_lcd_gnt1", 32'(lcd_gnt), 32'd0);
        step();
        check("t2_lcd_gnt",  32'(lcd_gnt), 32'd1);
        check("t2_cpu_gnt1", 32'(cpu_gnt), 32'd0);
        lcd_req = 0;
        step();
        step();
        check("t2_lcd_ack",  32'(lcd_ack), 32'd1);
        check("t2_lcd_rdata",32'(lcd_rdata), 32'h61);
        check("t2_cpu_keep", 32'(cpu_rdata), 32'h31);
        step();

        // 3: both held; expect CPU x4, LCD, CPU
        cpu_req = 1; cpu_addr = 8'h01;
        lcd_req = 1; lcd_addr = 8'h02;
        gcount = 0; guard = 0; gseq = '0;
        while (gcount < 6 && guard < 60) begin
            step();
            guard++;
            if (cpu_gnt || lcd_gnt) begin
                gseq[gcount] = lcd_gnt;
                if (gcount == 3)
                    check("t3_starve_full", 32'(dut.u_prio.starve_cnt), 32'd4);
                if (gcount == 4)
                    check("t3_starve_clr", 32'(dut.u_prio.starve_cnt), 32'd0);
                gcount++;
                if (gcount == 6) begin
                    cpu_req = 0; lcd_req = 0;
                end
            end
        end
        check("t3_grant_count", 32'(gcount), 32'd6);
        check("t3_grant_seq",   32'(gseq), 32'b010000);
        repeat (3) step();
        check("t3_cpu_rdata", 32'(cpu_rdata), 32'h04);
        check("t3_lcd_rdata", 32'(lcd_rdata), 32'h07);

        // 4: reset during WAIT of LCD read
        lcd_req = 1; lcd_we = 0; lcd_addr = 8'h30;
        step();
        check("t4_lcd_gnt", 32'(lcd_gnt), 32'd1);
        lcd_req = 0;
        step();                                        // WAIT
        sys_rst = 1'b0;
        step();
        check_outputs_zero("t4_rst");
        step();
        check("t4_no_ack", 32'(lcd_ack), 32'd0);
        sys_rst = 1'b1;
        step();
        check("t4_no_ack2", 32'(lcd_ack), 32'd0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h51;
        step();
        check("t4_cpu_gnt", 32'(cpu_gnt), 32'd1);
        cpu_req = 0;
        step();
        check("t4_lcd_ack3", 32'(lcd_ack), 32'd0);
        step();
        check("t4_cpu_ack",  32'(cpu_ack), 32'd1);
        check("t4_cpu_rdata",32'(cpu_rdata), 32'hF4);
        check("t4_lcd_rdata",32'(lcd_rdata), 32'd0);
        step();

        // 5: back-to-back CPU reads 0x00..0x03
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h00;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("t5_gnt%0d", k), 32'(cpu_gnt), 32'd1);
            cpu_addr = 8'(k + 1);
            if (k == 3) cpu_req = 0;
            step();
            check($sformatf("t5_wait%0d", k), 32'(cpu_ack), 32'd0);
            step();
            check($sformatf("t5_ack%0d", k), 32'(cpu_ack), 32'd1);
            check($sformatf("t5_rdata%0d", k), 32'(cpu_rdata), 32'(3 * k + 1));
        end
        step();
        check("t5_idle_gnt", 32'(cpu_gnt), 32'd0);

        // 6: RD_LAT=3 build, CPU read 0x42 (0xC7)
        b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 8'h42;
        step();                                        // T1
        check("t6_gnt",   32'(b_cpu_gnt), 32'd1);
        check("t6_rd_en", 32'(b_sram_rd_en), 32'd1);
        b_cpu_req = 0;
        for (int t = 2; t <= 4; t++) begin
            step();
            check($sformatf("t6_rd_en_T%0d", t), 32'(b_sram_rd_en), 32'd0);
            check($sformatf("t6_ack_T%0d", t),   32'(b_cpu_ack), 32'd0);
        end
        step();                                        // T5
        check("t6_ack",   32'(b_cpu_ack), 32'd1);
        check("t6_rdata", 32'(b_cpu_rdata), 32'hC7);
        check("t6_lcd_ack", 32'(b_lcd_ack), 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
